ycr_dmem_arbiter: RTL and testbench
===================================

// Module: ycr_dmem_arbiter
// PURPOSE
//  Two-requester round-robin arbiter for one YCR dmem-protocol target port (e.g. the dmem router input).
//  Shares the target between m0 (core LSU) and m1 (DMA/debug). Pipelined: one outstanding transaction.
//  Zero added latency. A response watchdog converts a hung target into RDY_ER for the owner.
// PARAMETERS
//  YCR_ARB_TIMEOUT  256  wait cycles before a forced RDY_ER; 0 disables the watchdog
//  YCR_ARB_TMR_W    9    watchdog counter width; must satisfy 2**W > YCR_ARB_TIMEOUT
// PORTS  (N = 0,1; AW = `YCR_DMEM_AWIDTH, DW = `YCR_DMEM_DWIDTH)
//  clk           in   1   clock
//  rst_n         in   1   reset, asynchronous, active-low
//  mN_req        in   1   requester N address-phase request
//  mN_cmd        in   1   YCR_MEM_CMD_RD / _WR
//  mN_width      in   2   byte/hword/word
//  mN_addr       in   AW  address
//  mN_wdata      in   DW  write data
//  mN_req_ack    out  1   address phase accepted for N
//  mN_rdata      out  DW  read data; '0 when N is not the owner
//  mN_resp       out  2   response to N; NOTRDY when N is not the owner
//  s_req         out  1   target request
//  s_cmd/s_width/s_addr/s_wdata  out  1/2/AW/DW  muxed from the selected requester
//  s_req_ack     in   1   target accepts the address phase
//  s_rdata       in   DW  target read data
//  s_resp        in   2   target response
//  arb_timeout   out  1   one-cycle pulse when the watchdog fires
// BEHAVIOUR
//  - Handshake: an address phase completes on a cycle with req & req_ack. Its response is the first
//    later cycle with resp != NOTRDY. Requesters hold req, cmd, addr, wdata and width stable until ack.
//  - FSM states: IDLE (nothing outstanding), DATA (one outstanding, owner register), DRAIN (timed out).
//  - Grant window: open in IDLE, or in DATA on the same cycle s_resp == RDY_OK (back-to-back).
//    Closed in DATA while NOTRDY, on RDY_ER, and in DRAIN. When closed: s_req = 0 and both mN_req_ack = 0.
//  - Selection: with one requester it is chosen. With both, the requester != last_grant is chosen.
//    Lock: if s_req was high and s_req_ack low, the same requester stays selected next cycle,
//    regardless of new arrivals. The lock clears on ack or when that req drops.
//  - The s_* outputs are a pure mux of the selected requester. mN_req_ack = s_req_ack & window & (sel==N).
//  - On accept: fsm->DATA, owner<=sel, last_grant<=sel, timer<=0.
//  - DATA: owner receives s_resp/s_rdata combinationally.
//    RDY_OK: -> DATA if a new accept occurs this cycle, else -> IDLE.
//    RDY_ER: -> IDLE. NOTRDY: timer+1.
//  - Watchdog (TIMEOUT != 0): in DATA with s_resp == NOTRDY and timer == TIMEOUT-1, the owner sees
//    mN_resp = RDY_ER and rdata '0 in that cycle. arb_timeout = 1, fsm -> DRAIN.
//  - DRAIN: no grants. The first s_resp != NOTRDY is discarded (not forwarded), then -> IDLE.
//    DRAIN has no timeout.
//  - Simultaneous response and accept: the old owner gets the response while the new requester gets
//    req_ack in the same cycle. This holds even when the new requester is the same master.
//  - Reset (any time, incl. mid-transaction): fsm=IDLE, last_grant=m1 (so m0 wins first tie), lock=0,
//    timer=0. All mN_resp = NOTRDY, arb_timeout = 0. No response is ever delivered for a killed transaction.
//  - Timer saturates; width arithmetic is unsigned YCR_ARB_TMR_W bits.
// STRUCTURE
//  - type_ycr_arb_fsm_e {IDLE,DATA,DRAIN} and the requester-select enum go into ycr_memif.svh,
//    alongside the existing YCR_MEM_RESP_*/CMD_*/WIDTH_* encodings (reused, not redefined).
//  - No sub-module. Flat RTL: select/lock logic, FSM, watchdog counter, response demux.
//  - Simulation-only SVA: no mN_req_ack while window closed; at most one mN_resp != NOTRDY per cycle.
// TESTING
//  1 m0 RD 0x0001_0004, target acks same cycle, RDY_OK data 0xA5A5_0000 two cycles later ->
//    m0_resp=RDY_OK, m0_rdata=0xA5A5_0000, m1_resp=NOTRDY throughout.
//  2 m0 and m1 request every cycle, target always acks, RDY_OK next cycle -> grants alternate
//    m0,m1,m0,m1 back-to-back with no idle cycle.
//  3 m1 requests and target withholds ack 3 cycles; m0 raises req during the wait ->
//    s_addr stays m1's, m1 acked first, m0 granted on m1's RDY_OK cycle.
//  4 TIMEOUT=8, m0 accepted at cycle T, target silent -> m0_resp=RDY_ER and arb_timeout=1 at T+8.
//    m1 req is blocked until the late target resp, which is not seen on m0/m1.
//  5 target returns RDY_ER for m1 WR -> m1_resp=RDY_ER; pending m0 acked no earlier than next cycle.
//  6 rst_n low while in DATA -> IDLE immediately; the later target resp is ignored;
//    first post-reset tie goes to m0.

Source files
------------

// File: rtl/ycr_dmem_arbiter_pkg.sv
// Shared encodings and types for the YCR dmem two-requester arbiter.
// The memory-protocol encodings match the existing YCR dmem interface values.
package ycr_dmem_arbiter_pkg;

  localparam int YCR_DMEM_AWIDTH = 32;
  localparam int YCR_DMEM_DWIDTH = 32;

  typedef enum logic [1:0] {
    YCR_MEM_RESP_NOTRDY = 2'b00,
    YCR_MEM_RESP_RDY_OK = 2'b01,
    YCR_MEM_RESP_RDY_ER = 2'b10
  } type_ycr_mem_resp_e;

  typedef enum logic {
    YCR_MEM_CMD_RD = 1'b0,
    YCR_MEM_CMD_WR = 1'b1
  } type_ycr_mem_cmd_e;

  typedef enum logic [1:0] {
    YCR_MEM_WIDTH_BYTE  = 2'b00,
    YCR_MEM_WIDTH_HWORD = 2'b01,
    YCR_MEM_WIDTH_WORD  = 2'b10
  } type_ycr_mem_width_e;

  typedef enum logic [1:0] {
    YCR_ARB_FSM_IDLE  = 2'b00,
    YCR_ARB_FSM_DATA  = 2'b01,
    YCR_ARB_FSM_DRAIN = 2'b10
  } type_ycr_arb_fsm_e;

  typedef enum logic {
    YCR_ARB_SEL_M0 = 1'b0,
    YCR_ARB_SEL_M1 = 1'b1
  } type_ycr_arb_sel_e;

  function automatic type_ycr_arb_sel_e ycr_arb_other(input type_ycr_arb_sel_e s);
    return (s == YCR_ARB_SEL_M0) ? YCR_ARB_SEL_M1 : YCR_ARB_SEL_M0;
  endfunction

endpackage

// File: rtl/ycr_dmem_arbiter.sv
// Round-robin arbiter sharing one dmem target between m0 (LSU) and m1 (DMA/debug).
// One outstanding transaction, zero added latency, with a watchdog that turns a hung target into RDY_ER.
module ycr_dmem_arbiter
  import ycr_dmem_arbiter_pkg::*;
#(
  parameter int YCR_ARB_TIMEOUT = 256,
  parameter int YCR_ARB_TMR_W   = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       m0_req,
  input  logic                       m0_cmd,
  input  logic [1:0]                 m0_width,
  input  logic [YCR_DMEM_AWIDTH-1:0] m0_addr,
  input  logic [YCR_DMEM_DWIDTH-1:0] m0_wdata,
  output logic                       m0_req_ack,
  output logic [YCR_DMEM_DWIDTH-1:0] m0_rdata,
  output logic [1:0]                 m0_resp,
  input  logic                       m1_req,
  input  logic                       m1_cmd,
  input  logic [1:0]                 m1_width,
  input  logic [YCR_DMEM_AWIDTH-1:0] m1_addr,
  input  logic [YCR_DMEM_DWIDTH-1:0] m1_wdata,
  output logic                       m1_req_ack,
  output logic [YCR_DMEM_DWIDTH-1:0] m1_rdata,
  output logic [1:0]                 m1_resp,
  output logic                       s_req,
  output logic                       s_cmd,
  output logic [1:0]                 s_width,
  output logic [YCR_DMEM_AWIDTH-1:0] s_addr,
  output logic [YCR_DMEM_DWIDTH-1:0] s_wdata,
  input  logic                       s_req_ack,
  input  logic [YCR_DMEM_DWIDTH-1:0] s_rdata,
  input  logic [1:0]                 s_resp,
  output logic                       arb_timeout
);

  localparam bit WD_EN = (YCR_ARB_TIMEOUT != 0);
  localparam logic [YCR_ARB_TMR_W-1:0] TMR_LAST = YCR_ARB_TMR_W'(YCR_ARB_TIMEOUT - 1);
  localparam logic [YCR_ARB_TMR_W-1:0] TMR_ONE  = YCR_ARB_TMR_W'(1);

  type_ycr_arb_fsm_e          fsm;
  type_ycr_arb_sel_e          owner;
  type_ycr_arb_sel_e          last_grant;
  type_ycr_arb_sel_e          lock_sel;
  type_ycr_arb_sel_e          sel;
  logic                       lock_q;
  logic                       lock_act;
  logic                       sel_req;
  logic                       window;
  logic                       accept;
  logic                       wd_fire;
  logic [YCR_ARB_TMR_W-1:0]   timer;
  logic [1:0]                 fwd_resp;
  logic [YCR_DMEM_DWIDTH-1:0] fwd_rdata;

  // A stalled address phase keeps its requester selected so the target never sees it change mid-wait.
  always_comb begin
    lock_act = lock_q & ((lock_sel == YCR_ARB_SEL_M0) ? m0_req : m1_req);
    if (lock_act)
      sel = lock_sel;
    else if (m0_req & m1_req)
      sel = ycr_arb_other(last_grant);
    else if (m1_req)
      sel = YCR_ARB_SEL_M1;
    else
      sel = YCR_ARB_SEL_M0;
  end

  always_comb begin
    sel_req  = (sel == YCR_ARB_SEL_M0) ? m0_req : m1_req;
    window   = (fsm == YCR_ARB_FSM_IDLE) |
               ((fsm == YCR_ARB_FSM_DATA) & (s_resp == YCR_MEM_RESP_RDY_OK));
    s_req    = window & sel_req;
    accept   = s_req & s_req_ack;
    s_cmd    = (sel == YCR_ARB_SEL_M0) ? m0_cmd   : m1_cmd;
    s_width  = (sel == YCR_ARB_SEL_M0) ? m0_width : m1_width;
    s_addr   = (sel == YCR_ARB_SEL_M0) ? m0_addr  : m1_addr;
    s_wdata  = (sel == YCR_ARB_SEL_M0) ? m0_wdata : m1_wdata;
    m0_req_ack = accept & (sel == YCR_ARB_SEL_M0);
    m1_req_ack = accept & (sel == YCR_ARB_SEL_M1);
  end

  // Watchdog firing substitutes RDY_ER for the owner; the late target reply is swallowed in DRAIN.
  always_comb begin
    wd_fire     = WD_EN & (fsm == YCR_ARB_FSM_DATA) &
                  (s_resp == YCR_MEM_RESP_NOTRDY) & (timer == TMR_LAST);
    arb_timeout = wd_fire;
    fwd_resp    = wd_fire ? YCR_MEM_RESP_RDY_ER : s_resp;
    fwd_rdata   = wd_fire ? '0 : s_rdata;
    m0_resp     = YCR_MEM_RESP_NOTRDY;
    m1_resp     = YCR_MEM_RESP_NOTRDY;
    m0_rdata    = '0;
    m1_rdata    = '0;
    if (fsm == YCR_ARB_FSM_DATA) begin
      if (owner == YCR_ARB_SEL_M0) begin
        m0_resp  = fwd_resp;
        m0_rdata = fwd_rdata;
      end else begin
        m1_resp  = fwd_resp;
        m1_rdata = fwd_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= YCR_ARB_FSM_IDLE;
      owner      <= YCR_ARB_SEL_M0;
      last_grant <= YCR_ARB_SEL_M1;
      lock_sel   <= YCR_ARB_SEL_M0;
      lock_q     <= 1'b0;
      timer      <= '0;
    end else begin
      lock_q   <= s_req & ~s_req_ack;
      lock_sel <= sel;
      if (accept) begin
        owner      <= sel;
        last_grant <= sel;
        timer      <= '0;
      end
      case (fsm)
        YCR_ARB_FSM_IDLE: begin
          if (accept) fsm <= YCR_ARB_FSM_DATA;
        end
        YCR_ARB_FSM_DATA: begin
          if (s_resp == YCR_MEM_RESP_RDY_OK) begin
            fsm <= accept ? YCR_ARB_FSM_DATA : YCR_ARB_FSM_IDLE;
          end else if (s_resp != YCR_MEM_RESP_NOTRDY) begin
            fsm <= YCR_ARB_FSM_IDLE;
          end else begin
            if (wd_fire) fsm <= YCR_ARB_FSM_DRAIN;
            if (timer != '1) timer <= timer + TMR_ONE;
          end
        end
        YCR_ARB_FSM_DRAIN: begin
          if (s_resp != YCR_MEM_RESP_NOTRDY) fsm <= YCR_ARB_FSM_IDLE;
        end
        default: fsm <= YCR_ARB_FSM_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_ack_when_closed: assert property (@(posedge clk) disable iff (!rst_n)
    !window |-> !(m0_req_ack | m1_req_ack));
  a_one_resp: assert property (@(posedge clk) disable iff (!rst_n)
    !((m0_resp != YCR_MEM_RESP_NOTRDY) && (m1_resp != YCR_MEM_RESP_NOTRDY)));
`endif

endmodule

// File: tb/tb_ycr_dmem_arbiter.sv
// Self-checking bench for ycr_dmem_arbiter: directed scenarios plus a randomized
// target/requester run scored against a transaction-level expectation.
module tb_ycr_dmem_arbiter;
  import ycr_dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic        cmd   [2];
  logic [1:0]  width [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        m0_req_ack, m1_req_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_resp, m1_resp;
  logic        s_req, s_cmd;
  logic [1:0]  s_width;
  logic [31:0] s_addr, s_wdata;
  logic        s_req_ack;
  logic [31:0] s_rdata;
  logic [1:0]  s_resp;
  logic        arb_timeout;

  int n_checks;
  int n_fails;

  ycr_dmem_arbiter #(.YCR_ARB_TIMEOUT(8), .YCR_ARB_TMR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_cmd(cmd[0]), .m0_width(width[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_req_ack(m0_req_ack), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
    .m1_req(req[1]), .m1_cmd(cmd[1]), .m1_width(width[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_req_ack(m1_req_ack), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
    .s_req(s_req), .s_cmd(s_cmd), .s_width(s_width), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_req_ack(s_req_ack), .s_rdata(s_rdata), .s_resp(s_resp),
    .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL global_time_limit: simulation time exceeded");
    $fatal(1, "[TB] time limit");
  end

  task automatic drive_idle();
    req       = 2'b00;
    s_req_ack = 1'b0;
    s_resp    = YCR_MEM_RESP_NOTRDY;
    s_rdata   = '0;
    for (int m = 0; m < 2; m++) begin
      cmd[m]   = YCR_MEM_CMD_RD;
      width[m] = YCR_MEM_WIDTH_WORD;
      addr[m]  = '0;
      wdata[m] = '0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n     = 1'b0;
    s_resp    = YCR_MEM_RESP_RDY_OK;
    s_req_ack = 1'b1;
    #2;
    if (m0_resp !== YCR_MEM_RESP_NOTRDY) begin $display("[TB] FAIL rst_m0_resp: got %0d want 0", m0_resp); n_fails++; end n_checks++;
    if (m1_resp !== YCR_MEM_RESP_NOTRDY) begin $display("[TB] FAIL rst_m1_resp: got %0d want 0", m1_resp); n_fails++; end n_checks++;
    if (arb_timeout !== 1'b0) begin $display("[TB] FAIL rst_timeout: got %0b want 0", arb_timeout); n_fails++; end n_checks++;
    if (s_req !== 1'b0) begin $display("[TB] FAIL rst_s_req: got %0b want 0", s_req); n_fails++; end n_checks++;
    apply_reset();
  endtask

  task automatic test_single_read();
    apply_reset();
    req[0] = 1'b1; cmd[0] = YCR_MEM_CMD_RD; addr[0] = 32'h0001_0004; s_req_ack = 1'b1;
    #2;
    if (s_addr !== 32'h0001_0004) begin $display("[TB] FAIL t1_s_addr: got %h want 00010004", s_addr); n_fails++; end n_checks++;
    if ({m1_req_ack, m0_req_ack} !== 2'b01) begin $display("[TB] FAIL t1_ack: got %b want 01", {m1_req_ack, m0_req_ack}); n_fails++; end n_checks++;
    next_cycle();
    req[0] = 1'b0; s_req_ack = 1'b0;
    #2;
    if (m0_resp !== YCR_MEM_RESP_NOTRDY) begin $display("[TB] FAIL t1_wait_resp: got %0d want 0", m0_resp); n_fails++; end n_checks++;
    next_cycle();
    s_resp = YCR_MEM_RESP_RDY_OK; s_rdata = 32'hA5A5_0000;
    #2;
    if (m0_resp !== YCR_MEM_RESP_RDY_OK) begin $display("[TB] FAIL t1_m0_resp: got %0d want 1", m0_resp); n_fails++; end n_checks++;
    if (m0_rdata !== 32'hA5A5_0000) begin $display("[TB] FAIL t1_m0_rdata: got %h want a5a50000", m0_rdata); n_fails++; end n_checks++;
    if (m1_resp !== YCR_MEM_RESP_NOTRDY) begin $display("[TB] FAIL t1_m1_resp: got %0d want 0", m1_resp); n_fails++; end n_checks++;
    next_cycle();
    drive_idle();
  endtask

  task automatic test_back_to_back();
    int exp;
    apply_reset();
    req = 2'b11; addr[0] = 32'h0000_0100; addr[1] = 32'h0000_0200;
    for (int k = 0; k < 6; k++) begin
      exp       = k % 2;
      s_req_ack = 1'b1;
      s_resp    = (k == 0) ? YCR_MEM_RESP_NOTRDY : YCR_MEM_RESP_RDY_OK;
      s_rdata   = 32'hB000_0000 + 32'(k);
      #2;
      if ({m1_req_ack, m0_req_ack} !== ((exp == 1) ? 2'b10 : 2'b01)) begin $display("[TB] FAIL b2b_grant%0d: got %b want m%0d", k, {m1_req_ack, m0_req_ack}, exp); n_fails++; end n_checks++;
      if (s_addr !== addr[exp]) begin $display("[TB] FAIL b2b_addr%0d: got %h want %h", k, s_addr, addr[exp]); n_fails++; end n_checks++;
      if (k > 0) begin
        if (((exp == 1) ? m0_resp : m1_resp) !== YCR_MEM_RESP_RDY_OK) begin $display("[TB] FAIL b2b_resp%0d: got %0d want 1", k, (exp == 1) ? m0_resp : m1_resp); n_fails++; end n_checks++;
        if (((exp == 1) ? m0_rdata : m1_rdata) !== 32'hB000_0000 + 32'(k)) begin $display("[TB] FAIL b2b_rdata%0d: got %h want %h", k, (exp == 1) ? m0_rdata : m1_rdata, 32'hB000_0000 + 32'(k)); n_fails++; end n_checks++;
      end
      next_cycle();
    end
    req = 2'b00; s_req_ack = 1'b0; s_resp = YCR_MEM_RESP_RDY_OK;
    #2;
    if (m1_resp !== YCR_MEM_RESP_RDY_OK) begin $display("[TB] FAIL b2b_last_resp: got %0d want 1", m1_resp); n_fails++; end n_checks++;
    next_cycle();
    drive_idle();
  endtask

  task automatic test_lock();
    apply_reset();
    addr[0] = 32'h0000_0A00; addr[1] = 32'h0000_0B00;
    req = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #2;
      if (s_addr !== 32'h0000_0B00) begin $display("[TB] FAIL lock_addr%0d: got %h want 00000b00", c, s_addr); n_fails++; end n_checks++;
      next_cycle();
      req = 2'b11;
    end
    s_req_ack = 1'b1;
    #2;
    if ({m1_req_ack, m0_req_ack} !== 2'b10) begin $display("[TB] FAIL lock_ack_m1: got %b want 10", {m1_req_ack, m0_req_ack}); n_fails++; end n_checks++;
    next_cycle();
    req = 2'b01;
    #2;
    if (m0_req_ack !== 1'b0) begin $display("[TB] FAIL lock_m0_early: got %0b want 0", m0_req_ack); n_fails++; end n_checks++;
    next_cycle();
    s_resp = YCR_MEM_RESP_RDY_OK;
    #2;
    if (m1_resp !== YCR_MEM_RESP_RDY_OK) begin $display("[TB] FAIL lock_m1_resp: got %0d want 1", m1_resp); n_fails++; end n_checks++;
    if (m0_req_ack !== 1'b1) begin $display("[TB] FAIL lock_m0_grant: got %0b want 1", m0_req_ack); n_fails++; end n_checks++;
    next_cycle();
    req = 2'b00; s_req_ack = 1'b0;
    #2;
    if (m0_resp !== YCR_MEM_RESP_RDY_OK) begin $display("[TB] FAIL lock_m0_resp: got %0d want 1", m0_resp); n_fails++; end n_checks++;
    next_cycle();
    drive_idle();
  endtask

  task automatic test_timeout();
    apply_reset();
    addr[0] = 32'h0000_0C00; addr[1] = 32'h0000_0D00;
    req = 2'b01; s_req_ack = 1'b1;
    next_cycle();
    req = 2'b10; s_rdata = 32'hDEAD_BEEF;
    for (int i = 1; i < 8; i++) begin
      #2;
      if (m0_resp !== YCR_MEM_RESP_NOTRDY) begin $display("[TB] FAIL tmo_wait_resp%0d: got %0d want 0", i, m0_resp); n_fails++; end n_checks++;
      if (arb_timeout !== 1'b0) begin $display("[TB] FAIL tmo_early%0d: got %0b want 0", i, arb_timeout); n_fails++; end n_checks++;
      if (m1_req_ack !== 1'b0) begin $display("[TB] FAIL tmo_m1_blocked%0d: got %0b want 0", i, m1_req_ack); n_fails++; end n_checks++;
      next_cycle();
    end
    #2;
    if (m0_resp !== YCR_MEM_RESP_RDY_ER) begin $display("[TB] FAIL tmo_m0_er: got %0d want 2", m0_resp); n_fails++; end n_checks++;
    if (m0_rdata !== 32'h0) begin $display("[TB] FAIL tmo_m0_rdata: got %h want 0", m0_rdata); n_fails++; end n_checks++;
    if (arb_timeout !== 1'b1) begin $display("[TB] FAIL tmo_pulse: got %0b want 1", arb_timeout); n_fails++; end n_checks++;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      #2;
      if ({m1_req_ack, arb_timeout} !== 2'b00) begin $display("[TB] FAIL tmo_drain%0d: got %b want 00", i, {m1_req_ack, arb_timeout}); n_fails++; end n_checks++;
      next_cycle();
    end
    s_resp = YCR_MEM_RESP_RDY_OK;
    #2;
    if ({m1_resp, m0_resp} !== 4'b0000) begin $display("[TB] FAIL tmo_late_resp: got %b want 0000", {m1_resp, m0_resp}); n_fails++; end n_checks++;
    if (m1_req_ack !== 1'b0) begin $display("[TB] FAIL tmo_m1_drain_ack: got %0b want 0", m1_req_ack); n_fails++; end n_checks++;
    next_cycle();
    s_resp = YCR_MEM_RESP_NOTRDY;
    #2;
    if (m1_req_ack !== 1'b1) begin $display("[TB] FAIL tmo_m1_grant: got %0b want 1", m1_req_ack); n_fails++; end n_checks++;
    next_cycle();
    req = 2'b00; s_req_ack = 1'b0; s_resp = YCR_MEM_RESP_RDY_OK;
    #2;
    if (m1_resp !== YCR_MEM_RESP_RDY_OK) begin $display("[TB] FAIL tmo_m1_resp: got %0d want 1", m1_resp); n_fails++; end n_checks++;
    next_cycle();
    drive_idle();
  endtask

  task automatic test_error_resp();
    apply_reset();
    addr[0] = 32'h0000_0E00; addr[1] = 32'h0000_0F00; cmd[1] = YCR_MEM_CMD_WR; wdata[1] = 32'h1234_5678;
    req = 2'b10; s_req_ack = 1'b1;
    #2;
    if (m1_req_ack !== 1'b1) begin $display("[TB] FAIL err_m1_ack: got %0b want 1", m1_req_ack); n_fails++; end n_checks++;
    if (s_wdata !== 32'h1234_5678) begin $display("[TB] FAIL err_wdata: got %h want 12345678", s_wdata); n_fails++; end n_checks++;
    next_cycle();
    req = 2'b01;
    #2;
    if (m0_req_ack !== 1'b0) begin $display("[TB] FAIL err_m0_wait: got %0b want 0", m0_req_ack); n_fails++; end n_checks++;
    next_cycle();
    s_resp = YCR_MEM_RESP_RDY_ER;
    #2;
    if (m1_resp !== YCR_MEM_RESP_RDY_ER) begin $display("[TB] FAIL err_m1_resp: got %0d want 2", m1_resp); n_fails++; end n_checks++;
    if (m0_req_ack !== 1'b0) begin $display("[TB] FAIL err_m0_same_cycle: got %0b want 0", m0_req_ack); n_fails++; end n_checks++;
    next_cycle();
    s_resp = YCR_MEM_RESP_NOTRDY;
    #2;
    if (m0_req_ack !== 1'b1) begin $display("[TB] FAIL err_m0_next: got %0b want 1", m0_req_ack); n_fails++; end n_checks++;
    next_cycle();
    req = 2'b00; s_req_ack = 1'b0; s_resp = YCR_MEM_RESP_RDY_OK;
    #2;
    if (m0_resp !== YCR_MEM_RESP_RDY_OK) begin $display("[TB] FAIL err_m0_resp: got %0d want 1", m0_resp); n_fails++; end n_checks++;
    next_cycle();
    drive_idle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    addr[0] = 32'h0000_1000; addr[1] = 32'h0000_2000;
    req = 2'b01; s_req_ack = 1'b1;
    next_cycle();
    req = 2'b00; s_req_ack = 1'b0;
    #1;
    rst_n = 1'b0; s_resp = YCR_MEM_RESP_RDY_OK; s_rdata = 32'h0000_1234;
    #1;
    if (m0_resp !== YCR_MEM_RESP_NOTRDY) begin $display("[TB] FAIL rmid_m0_resp: got %0d want 0", m0_resp); n_fails++; end n_checks++;
    #2 rst_n = 1'b1;
    next_cycle();
    req = 2'b11; s_req_ack = 1'b1;
    #2;
    if ({m1_resp, m0_resp} !== 4'b0000) begin $display("[TB] FAIL rmid_killed_resp: got %b want 0000", {m1_resp, m0_resp}); n_fails++; end n_checks++;
    if ({m1_req_ack, m0_req_ack} !== 2'b01) begin $display("[TB] FAIL rmid_tie: got %b want 01", {m1_req_ack, m0_req_ack}); n_fails++; end n_checks++;
    next_cycle();
    req = 2'b00; s_req_ack = 1'b0;
    #2;
    if (m0_resp !== YCR_MEM_RESP_RDY_OK) begin $display("[TB] FAIL rmid_m0_resp2: got %0d want 1", m0_resp); n_fails++; end n_checks++;
    next_cycle();
    drive_idle();
  endtask

  // Requesters issue random transactions; the target model answers each accepted one after 0..3 waits.
  task automatic test_random(input int ncyc);
    bit          outst;
    bit          acked [2];
    bit          exp_acc;
    int          owner_m;
    int          lat;
    int          a;
    logic [1:0]  rsp;
    logic [31:0] rdat;
    logic [1:0]  got;
    apply_reset();
    outst = 1'b0; owner_m = 0; lat = 0;
    acked[0] = 1'b0; acked[1] = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (acked[m] || !req[m]) begin
          if ($urandom_range(0, 1) == 1) begin
            req[m]   = 1'b1;
            cmd[m]   = 1'($urandom_range(0, 1));
            width[m] = 2'($urandom_range(0, 2));
            addr[m]  = {(m == 1) ? 8'hB1 : 8'hA0, 24'($urandom)};
            wdata[m] = $urandom;
          end else begin
            req[m] = 1'b0;
          end
        end
      end
      rdat = $urandom;
      if (outst && lat == 0)
        rsp = ($urandom_range(0, 4) == 0) ? YCR_MEM_RESP_RDY_ER : YCR_MEM_RESP_RDY_OK;
      else
        rsp = YCR_MEM_RESP_NOTRDY;
      s_resp = rsp; s_rdata = rdat;
      s_req_ack = ($urandom_range(0, 2) != 0);
      #2;
      if (outst && rsp != YCR_MEM_RESP_NOTRDY) begin
        if (((owner_m == 1) ? m1_resp : m0_resp) !== rsp) begin $display("[TB] FAIL rnd_resp c%0d: got %0d want %0d", c, (owner_m == 1) ? m1_resp : m0_resp, rsp); n_fails++; end n_checks++;
        if (((owner_m == 1) ? m1_rdata : m0_rdata) !== rdat) begin $display("[TB] FAIL rnd_rdata c%0d: got %h want %h", c, (owner_m == 1) ? m1_rdata : m0_rdata, rdat); n_fails++; end n_checks++;
        if (((owner_m == 1) ? m0_resp : m1_resp) !== YCR_MEM_RESP_NOTRDY) begin $display("[TB] FAIL rnd_other_resp c%0d: got %0d want 0", c, (owner_m == 1) ? m0_resp : m1_resp); n_fails++; end n_checks++;
      end else begin
        if ({m1_resp, m0_resp} !== 4'b0000) begin $display("[TB] FAIL rnd_idle_resp c%0d: got %b want 0000", c, {m1_resp, m0_resp}); n_fails++; end n_checks++;
      end
      exp_acc = (req != 2'b00) && s_req_ack && (!outst || rsp == YCR_MEM_RESP_RDY_OK);
      got     = {m1_req_ack, m0_req_ack};
      if ((exp_acc && !(got == 2'b01 || got == 2'b10)) || (!exp_acc && got !== 2'b00)) begin
        $display("[TB] FAIL rnd_accept c%0d: got acks %b want accept=%0b", c, got, exp_acc); n_fails++;
      end
      n_checks++;
      acked[0] = m0_req_ack; acked[1] = m1_req_ack;
      if (outst && rsp != YCR_MEM_RESP_NOTRDY) outst = 1'b0;
      else if (outst) lat--;
      if (acked[0] || acked[1]) begin
        a = acked[1] ? 1 : 0;
        if (req[a] !== 1'b1) begin $display("[TB] FAIL rnd_ack_noreq c%0d: m%0d req %b want 1", c, a, req[a]); n_fails++; end n_checks++;
        if ({s_addr, s_wdata, s_cmd, s_width} !== {addr[a], wdata[a], cmd[a], width[a]}) begin
          $display("[TB] FAIL rnd_mux c%0d: got %h/%h/%b/%0d want %h/%h/%b/%0d", c, s_addr, s_wdata, s_cmd, s_width, addr[a], wdata[a], cmd[a], width[a]); n_fails++;
        end
        n_checks++;
        outst = 1'b1; owner_m = a; lat = $urandom_range(0, 3);
      end
      next_cycle();
    end
    drive_idle();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    drive_idle();
    rst_n = 1'b0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_lock();
    test_timeout();
    test_error_resp();
    test_reset_mid();
    test_random(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
